// File: rtl/ysyx_22040237_imem_resp.sv
// Instruction memory responder: a single-outstanding fetch port with fixed
// request-to-response latency, plus a backdoor word-load port.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req_valid/ready   fetch request handshake, req_addr = byte address (pc)
//   resp_valid/ready  response handshake, resp_inst = word, resp_err = bad address
//   ld_en/addr/data   backdoor word write, accepted in every state
//   busy              high whenever the FSM is not IDLE
//   resp_count        completed response handshakes, wrapping at 16 bits
module ysyx_22040237_imem_resp #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic                  resp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  busy,
    output logic [15:0]           resp_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic               req_ready_q, req_ready_d;
    logic               valid_d, err_d, busy_d;
    logic [31:0]        inst_d;
    logic [15:0]        count_d;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        offset;
    logic               addr_ok;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [31:0]        rd_word;

    // Backdoor loads; storage is deliberately outside reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Address decode of the latched request.
    assign offset  = addr_q - BASE_ADDR;
    assign rd_idx  = offset[DEPTH_LOG2+1:2];
    assign addr_ok = (addr_q[1:0] == 2'b00) && (addr_q >= BASE_ADDR)
                     && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    // Read sees pre-edge contents, so a load on the WAIT->RESP edge returns the old word.
    assign rd_word = mem[rd_idx];

    // Reset must suppress acceptance immediately, not one cycle later.
    assign req_ready = req_ready_q & rst;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = resp_valid;
        inst_d  = resp_inst;
        err_d   = resp_err;
        count_d = resp_count;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = WAIT;
                    addr_d  = req_addr;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    inst_d  = addr_ok ? rd_word : 32'h0000_0000;
                    err_d   = ~addr_ok;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    count_d = resp_count + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            resp_valid  <= 1'b0;
            resp_inst   <= 32'h0000_0000;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
            resp_count  <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            resp_valid  <= valid_d;
            resp_inst   <= inst_d;
            resp_err    <= err_d;
            busy        <= busy_d;
            resp_count  <= count_d;
        end
    end

endmodule
